// File: rtl/slicer_err_gen.sv
// rtl/slicer_err_gen.sv - decision-directed 4-ASK slicer with error output and averaging-window strobe
module slicer_err_gen #(
    parameter int LFSR_WID = 22
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                sym_clk_en,
    input  logic signed [17:0]  sample_in,
    input  logic signed [17:0]  ref_level,
    output logic [1:0]          decision,
    output logic signed [17:0]  error,
    output logic                err_valid,
    output logic                clr_acc
);

    logic signed [17:0]    s1;
    logic                  s1_valid;
    logic signed [17:0]    ref_hold;
    logic                  ref_reload;
    logic [LFSR_WID-1:0]   win_cnt;

    logic signed [17:0]    ref_clamped;
    logic signed [17:0]    a_cur;
    logic signed [19:0]    a_w;
    logic signed [19:0]    two_a;
    logic signed [19:0]    three_a;
    logic signed [19:0]    s1_w;
    logic signed [19:0]    level;
    logic signed [19:0]    diff;
    logic [1:0]            dec_nx;
    logic signed [17:0]    err_nx;

    // The reload strobe also writes the window's first error, so it slices
    // against the incoming reference to keep one level per window.
    always_comb begin
        ref_clamped = ref_level[17] ? 18'sd0 : ref_level;
        a_cur       = ref_reload ? ref_clamped : ref_hold;
        a_w         = {{2{a_cur[17]}}, a_cur};
        two_a       = a_w <<< 1;
        three_a     = two_a + a_w;
        s1_w        = {{2{s1[17]}}, s1};
        dec_nx      = 2'b00;
        level       = -three_a;
        if (s1_w >= two_a) begin
            dec_nx = 2'b11;
            level  = three_a;
        end else if (s1_w >= 20'sd0) begin
            dec_nx = 2'b10;
            level  = a_w;
        end else if (s1_w >= -two_a) begin
            dec_nx = 2'b01;
            level  = -a_w;
        end
        diff = s1_w - level;
        if (diff > 20'sd131071)
            err_nx = 18'sh1ffff;
        else if (diff < -20'sd131072)
            err_nx = 18'sh20000;
        else
            err_nx = diff[17:0];
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s1         <= '0;
            s1_valid   <= 1'b0;
            ref_hold   <= '0;
            ref_reload <= 1'b1;
            win_cnt    <= '0;
            decision   <= 2'b00;
            error      <= '0;
            err_valid  <= 1'b0;
            clr_acc    <= 1'b0;
        end else begin
            clr_acc <= 1'b0;
            if (clr_acc)
                ref_reload <= 1'b1;
            if (sym_clk_en) begin
                s1        <= sample_in;
                s1_valid  <= 1'b1;
                decision  <= dec_nx;
                error     <= err_nx;
                err_valid <= s1_valid;
                if (ref_reload) begin
                    ref_hold   <= ref_clamped;
                    ref_reload <= 1'b0;
                end
                // Only real errors advance the window; wrap marks its last one.
                if (s1_valid) begin
                    win_cnt <= win_cnt + LFSR_WID'(1);
                    if (win_cnt == '1)
                        clr_acc <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slicer_err_gen.sv
// tb/tb_slicer_err_gen.sv - directed-vector bench for slicer_err_gen
module tb_slicer_err_gen;

    logic               sys_clk = 1'b0;
    logic               reset = 1'b1;
    logic               sym_clk_en = 1'b0;
    logic signed [17:0] sample_in = '0;
    logic signed [17:0] ref_level = '0;
    logic [1:0]         decision;
    logic signed [17:0] error;
    logic               err_valid;
    logic               clr_acc;

    int n_vec = 0;
    int n_bad = 0;

    slicer_err_gen #(.LFSR_WID(4)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .sample_in  (sample_in),
        .ref_level  (ref_level),
        .decision   (decision),
        .error      (error),
        .err_valid  (err_valid),
        .clr_acc    (clr_acc)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic signed [17:0] smp;
        logic signed [17:0] refl;
        logic [1:0]         dec;
        int                 err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset = 1'b1;
        sym_clk_en = 1'b0;
        @(negedge sys_clk);
        reset = 1'b0;
    endtask

    // One strobe followed by three idle cycles; reports the pulse seen right
    // after the strobe and any clr_acc activity in the other three cycles.
    task automatic strobe(input logic signed [17:0] smp, output logic pulse, output int extra);
        @(negedge sys_clk);
        sample_in  = smp;
        sym_clk_en = 1'b1;
        extra      = int'(clr_acc);
        @(negedge sys_clk);
        sym_clk_en = 1'b0;
        pulse      = clr_acc;
        @(negedge sys_clk);
        extra += int'(clr_acc);
        @(negedge sys_clk);
        extra += int'(clr_acc);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_decision"}, int'(decision), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_err_valid"}, int'(err_valid), 0);
        check({tag, "_clr_acc"}, int'(clr_acc), 0);
    endtask

    initial begin
        logic pulse;
        int   extra;
        logic exp_pulse;
        int   j;

        vecs[0] = '{18'sd52429,    18'sd16384,  2'b11, 3277};
        vecs[1] = '{-18'sd6554,    18'sd16384,  2'b01, 9830};
        vecs[2] = '{18'sd0,        18'sd16384,  2'b10, -16384};
        vecs[3] = '{18'sd32768,    18'sd16384,  2'b11, -16384};
        vecs[4] = '{18'sd5,        -18'sd100,   2'b11, 5};
        vecs[5] = '{-18'sd32768,   18'sd16384,  2'b01, -16384};
        vecs[6] = '{-18'sd32769,   18'sd16384,  2'b00, 16383};
        vecs[7] = '{18'sd131071,   18'sd0,      2'b11, 131071};
        vecs[8] = '{-18'sd131072,  18'sd0,      2'b00, -131072};
        vecs[9] = '{18'sd100000,   18'sd40000,  2'b11, -20000};

        ref_level = 18'sd16384;
        do_reset();
        check_zero_outputs("reset");

        foreach (vecs[i]) begin
            ref_level = vecs[i].refl;
            do_reset();
            strobe(vecs[i].smp, pulse, extra);
            check($sformatf("v%0d_valid_early", i), int'(err_valid), 0);
            strobe(18'sd0, pulse, extra);
            check($sformatf("v%0d_valid", i), int'(err_valid), 1);
            check($sformatf("v%0d_decision", i), int'(decision), int'(vecs[i].dec));
            check($sformatf("v%0d_error", i), int'(error), vecs[i].err);
        end

        // Window strobes and reference hold across a window boundary.
        ref_level = 18'sd16384;
        do_reset();
        for (int k = 1; k <= 55; k++) begin
            if (k == 6)
                ref_level = 18'sd32768;
            strobe(18'sd52429, pulse, extra);
            exp_pulse = (k >= 17) && (((k - 17) % 16) == 0);
            check($sformatf("win_pulse_k%0d", k), int'(pulse), int'(exp_pulse));
            check($sformatf("win_extra_k%0d", k), extra, 0);
            check($sformatf("win_valid_k%0d", k), int'(err_valid), (k >= 2) ? 1 : 0);
            if (k >= 2 && k <= 17) begin
                check($sformatf("hold_dec_k%0d", k), int'(decision), 3);
                check($sformatf("hold_err_k%0d", k), int'(error), 3277);
            end else if (k >= 18) begin
                check($sformatf("new_dec_k%0d", k), int'(decision), 2);
                check($sformatf("new_err_k%0d", k), int'(error), 19661);
            end
        end

        // Reset coincident with a strobe, six errors into a window.
        @(negedge sys_clk);
        reset      = 1'b1;
        sym_clk_en = 1'b1;
        sample_in  = 18'sd52429;
        @(negedge sys_clk);
        reset      = 1'b0;
        sym_clk_en = 1'b0;
        check_zero_outputs("midreset");
        @(negedge sys_clk);
        for (j = 1; j <= 20; j++) begin
            strobe(18'sd52429, pulse, extra);
            check($sformatf("rst_valid_j%0d", j), int'(err_valid), (j >= 2) ? 1 : 0);
            check($sformatf("rst_pulse_j%0d", j), int'(pulse), (j == 17) ? 1 : 0);
            check($sformatf("rst_extra_j%0d", j), extra, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
